// File: rtl/wave_read_arbiter_if.sv
// Wave read arbiter bus bundle: requester strobes and indices, returned
// samples with valid pulses, and the wave BRAM read port.
// master = requester/BRAM side, slave = arbiter side.
interface wave_read_arbiter_if #(
  parameter int NUM_OSCILLATORS = 1,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int WW_WIDTH        = 15
);

  // Shared controls
  logic [WW_WIDTH-1:0]                          wave_width_in;
  logic                                         freeze_in;

  // Oscillator voices
  logic [NUM_OSCILLATORS-1:0]                   osc_req_in;
  logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]     osc_index_in;
  logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0] osc_data_out;
  logic [NUM_OSCILLATORS-1:0]                   osc_valid_out;

  // HDMI visualiser
  logic                                         viz_req_in;
  logic [WW_WIDTH-1:0]                          viz_index_in;
  logic [SAMPLE_WIDTH-1:0]                      viz_data_out;
  logic                                         viz_valid_out;

  // UART debugger
  logic                                         dbg_req_in;
  logic [WW_WIDTH-1:0]                          dbg_index_in;
  logic [SAMPLE_WIDTH-1:0]                      dbg_data_out;
  logic                                         dbg_valid_out;

  // Wave BRAM read port
  logic                                         bram_en_out;
  logic [WW_WIDTH-1:0]                          bram_addr_out;
  logic [SAMPLE_WIDTH-1:0]                      bram_data_in;

  modport master (
    output wave_width_in, freeze_in,
    output osc_req_in, osc_index_in,
    output viz_req_in, viz_index_in,
    output dbg_req_in, dbg_index_in,
    output bram_data_in,
    input  osc_data_out, osc_valid_out,
    input  viz_data_out, viz_valid_out,
    input  dbg_data_out, dbg_valid_out,
    input  bram_en_out, bram_addr_out
  );

  modport slave (
    input  wave_width_in, freeze_in,
    input  osc_req_in, osc_index_in,
    input  viz_req_in, viz_index_in,
    input  dbg_req_in, dbg_index_in,
    input  bram_data_in,
    output osc_data_out, osc_valid_out,
    output viz_data_out, viz_valid_out,
    output dbg_data_out, dbg_valid_out,
    output bram_en_out, bram_addr_out
  );

endinterface

// File: rtl/wave_read_arbiter.sv
// Wave read arbiter: shares the single wave BRAM read port between the
// oscillator voices, the HDMI visualiser and the UART debugger. Requests are
// captured (newest index wins), at most one read is issued per cycle, and each
// returned sample is routed back to its requester with a one-cycle valid.
module wave_read_arbiter #(
  parameter int NUM_OSCILLATORS = 1,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int WW_WIDTH        = 15,
  parameter int READ_LATENCY    = 2,
  parameter int STARVE_LIMIT    = 16
) (
  input logic                clk_in,
  input logic                rst_in,
  wave_read_arbiter_if.slave bus
);

  // Requester IDs: oscillators 0..N-1, then visualiser, then debugger.
  localparam int ID_W  = $clog2(NUM_OSCILLATORS + 2);
  localparam int OSC_W = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [ID_W-1:0]  VIZ_ID     = ID_W'(NUM_OSCILLATORS);
  localparam logic [ID_W-1:0]  DBG_ID     = ID_W'(NUM_OSCILLATORS + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [OSC_W-1:0] LAST_OSC   = OSC_W'(NUM_OSCILLATORS - 1);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_OSC,
    GRANT_VIZ,
    GRANT_DBG
  } grant_e;

  // Captured requests
  logic [NUM_OSCILLATORS-1:0]                   oscPend_q, oscPend_d;
  logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]     oscIdx_q;
  logic                                         vizPend_q, vizPend_d;
  logic                                         dbgPend_q, dbgPend_d;
  logic [WW_WIDTH-1:0]                          vizIdx_q, dbgIdx_q;

  // Fairness state
  logic [CNT_W-1:0]                             vizWait_q, vizWait_d;
  logic [CNT_W-1:0]                             dbgWait_q, dbgWait_d;
  logic [OSC_W-1:0]                             rrPtr_q, rrPtr_d;
  logic                                         lowPrefDbg_q, lowPrefDbg_d;

  // Issue stage (drives the BRAM port)
  logic                                         bramEn_q, bramEn_d;
  logic [WW_WIDTH-1:0]                          bramAddr_q, bramAddr_d;
  logic [ID_W-1:0]                              issueId_q, issueId_d;

  // Tags of reads in flight, aligned with the BRAM latency
  logic [READ_LATENCY-1:0]                      tagValid_q;
  logic [READ_LATENCY-1:0][ID_W-1:0]            tagId_q;

  // Return registers
  logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0] oscData_q;
  logic [NUM_OSCILLATORS-1:0]                   oscValid_q;
  logic [SAMPLE_WIDTH-1:0]                      vizData_q, dbgData_q;
  logic                                         vizValid_q, dbgValid_q;

  // Combinational grant decision
  grant_e                                       grantKind;
  logic [OSC_W-1:0]                             grantOsc;
  logic                                         oscFound;
  logic [NUM_OSCILLATORS-1:0]                   oscGrantVec;
  logic                                         vizGrant, dbgGrant;
  logic                                         vizStarving, dbgStarving;
  logic [WW_WIDTH-1:0]                          selIdx, clampAddr;
  logic                                         retValid;
  logic [ID_W-1:0]                              retId;

  // Oscillator slot reached by stepping 'offset' places past 'base', wrapping.
  function automatic logic [OSC_W-1:0] rrSlot(input logic [OSC_W-1:0] base,
                                              input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_OSCILLATORS) begin
      sum = sum - NUM_OSCILLATORS;
    end
    return OSC_W'(sum);
  endfunction

  assign vizStarving = vizPend_q && (vizWait_q >= STARVE_MAX);
  assign dbgStarving = dbgPend_q && (dbgWait_q >= STARVE_MAX);

  // Pick at most one requester: starving viz/dbg, then oscillators round-robin, then viz/dbg alternating.
  always_comb begin
    grantKind = GRANT_NONE;
    grantOsc  = '0;
    oscFound  = 1'b0;
    for (int i = 0; i < NUM_OSCILLATORS; i++) begin
      if (!oscFound && oscPend_q[rrSlot(rrPtr_q, i)]) begin
        oscFound = 1'b1;
        grantOsc = rrSlot(rrPtr_q, i);
      end
    end
    if (!bus.freeze_in) begin
      if (vizStarving) begin
        grantKind = GRANT_VIZ;
      end else if (dbgStarving) begin
        grantKind = GRANT_DBG;
      end else if (oscFound) begin
        grantKind = GRANT_OSC;
      end else if (vizPend_q && dbgPend_q) begin
        grantKind = lowPrefDbg_q ? GRANT_DBG : GRANT_VIZ;
      end else if (vizPend_q) begin
        grantKind = GRANT_VIZ;
      end else if (dbgPend_q) begin
        grantKind = GRANT_DBG;
      end
    end
  end

  // Decode the grant into per-requester strobes and the captured index to read.
  always_comb begin
    oscGrantVec = '0;
    vizGrant    = 1'b0;
    dbgGrant    = 1'b0;
    selIdx      = '0;
    case (grantKind)
      GRANT_OSC: begin
        oscGrantVec[grantOsc] = 1'b1;
        selIdx                = oscIdx_q[grantOsc];
      end
      GRANT_VIZ: begin
        vizGrant = 1'b1;
        selIdx   = vizIdx_q;
      end
      GRANT_DBG: begin
        dbgGrant = 1'b1;
        selIdx   = dbgIdx_q;
      end
      default: begin
        selIdx = '0;
      end
    endcase
  end

  // Keep reads inside the current wave; an empty wave reads address 0.
  always_comb begin
    if (bus.wave_width_in == '0) begin
      clampAddr = '0;
    end else if (selIdx >= bus.wave_width_in) begin
      clampAddr = bus.wave_width_in - WW_WIDTH'(1);
    end else begin
      clampAddr = selIdx;
    end
  end

  // Next-state for pending bits, wait counters, fairness pointers and issue stage.
  always_comb begin
    oscPend_d    = (oscPend_q & ~oscGrantVec) | bus.osc_req_in;
    vizPend_d    = (vizPend_q & ~vizGrant) | bus.viz_req_in;
    dbgPend_d    = (dbgPend_q & ~dbgGrant) | bus.dbg_req_in;

    vizWait_d    = vizWait_q;
    dbgWait_d    = dbgWait_q;
    rrPtr_d      = rrPtr_q;
    lowPrefDbg_d = lowPrefDbg_q;

    if (!vizPend_q || vizGrant) begin
      vizWait_d = '0;
    end else if (vizWait_q < STARVE_MAX) begin
      vizWait_d = vizWait_q + CNT_W'(1);
    end

    if (!dbgPend_q || dbgGrant) begin
      dbgWait_d = '0;
    end else if (dbgWait_q < STARVE_MAX) begin
      dbgWait_d = dbgWait_q + CNT_W'(1);
    end

    if (grantKind == GRANT_OSC) begin
      rrPtr_d = (grantOsc == LAST_OSC) ? '0 : grantOsc + OSC_W'(1);
    end
    if (vizGrant) begin
      lowPrefDbg_d = 1'b1;
    end else if (dbgGrant) begin
      lowPrefDbg_d = 1'b0;
    end

    bramEn_d   = (grantKind != GRANT_NONE);
    bramAddr_d = bramAddr_q;
    issueId_d  = issueId_q;
    case (grantKind)
      GRANT_OSC: begin
        bramAddr_d = clampAddr;
        issueId_d  = ID_W'(grantOsc);
      end
      GRANT_VIZ: begin
        bramAddr_d = clampAddr;
        issueId_d  = VIZ_ID;
      end
      GRANT_DBG: begin
        bramAddr_d = clampAddr;
        issueId_d  = DBG_ID;
      end
      default: begin
        bramAddr_d = bramAddr_q;
      end
    endcase
  end

  // Capture request strobes; a strobe always loads the newest index.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      oscPend_q <= '0;
      oscIdx_q  <= '0;
      vizPend_q <= 1'b0;
      vizIdx_q  <= '0;
      dbgPend_q <= 1'b0;
      dbgIdx_q  <= '0;
    end else begin
      oscPend_q <= oscPend_d;
      vizPend_q <= vizPend_d;
      dbgPend_q <= dbgPend_d;
      for (int i = 0; i < NUM_OSCILLATORS; i++) begin
        if (bus.osc_req_in[i]) begin
          oscIdx_q[i] <= bus.osc_index_in[i];
        end
      end
      if (bus.viz_req_in) begin
        vizIdx_q <= bus.viz_index_in;
      end
      if (bus.dbg_req_in) begin
        dbgIdx_q <= bus.dbg_index_in;
      end
    end
  end

  // Register fairness state and the BRAM issue stage.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      vizWait_q    <= '0;
      dbgWait_q    <= '0;
      rrPtr_q      <= '0;
      lowPrefDbg_q <= 1'b0;
      bramEn_q     <= 1'b0;
      bramAddr_q   <= '0;
      issueId_q    <= '0;
    end else begin
      vizWait_q    <= vizWait_d;
      dbgWait_q    <= dbgWait_d;
      rrPtr_q      <= rrPtr_d;
      lowPrefDbg_q <= lowPrefDbg_d;
      bramEn_q     <= bramEn_d;
      bramAddr_q   <= bramAddr_d;
      issueId_q    <= issueId_d;
    end
  end

  // Carry each issued read's requester ID alongside the BRAM latency.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      tagValid_q <= '0;
      tagId_q    <= '0;
    end else begin
      tagValid_q[0] <= bramEn_q;
      tagId_q[0]    <= issueId_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
        tagValid_q[k] <= tagValid_q[k-1];
        tagId_q[k]    <= tagId_q[k-1];
      end
    end
  end

  assign retValid = tagValid_q[READ_LATENCY-1];
  assign retId    = tagId_q[READ_LATENCY-1];

  // Route returning BRAM data to the tagged requester with a one-cycle valid.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      oscData_q  <= '0;
      oscValid_q <= '0;
      vizData_q  <= '0;
      vizValid_q <= 1'b0;
      dbgData_q  <= '0;
      dbgValid_q <= 1'b0;
    end else begin
      oscValid_q <= '0;
      vizValid_q <= 1'b0;
      dbgValid_q <= 1'b0;
      if (retValid) begin
        if (retId == VIZ_ID) begin
          vizData_q  <= bus.bram_data_in;
          vizValid_q <= 1'b1;
        end else if (retId == DBG_ID) begin
          dbgData_q  <= bus.bram_data_in;
          dbgValid_q <= 1'b1;
        end else begin
          oscData_q[retId[OSC_W-1:0]]  <= bus.bram_data_in;
          oscValid_q[retId[OSC_W-1:0]] <= 1'b1;
        end
      end
    end
  end

  assign bus.bram_en_out   = bramEn_q;
  assign bus.bram_addr_out = bramAddr_q;
  assign bus.osc_data_out  = oscData_q;
  assign bus.osc_valid_out = oscValid_q;
  assign bus.viz_data_out  = vizData_q;
  assign bus.viz_valid_out = vizValid_q;
  assign bus.dbg_data_out  = dbgData_q;
  assign bus.dbg_valid_out = dbgValid_q;

endmodule

// File: tb/tb_wave_read_arbiter.sv
// Directed bench for wave_read_arbiter with three oscillators. The BRAM is a
// two-cycle-latency model whose word at address a is 16'h8000 | a, with a
// manual override for hand-picked data.
module tb_wave_read_arbiter;

  localparam int NOSC = 3;
  localparam int SW   = 16;
  localparam int WW   = 15;
  localparam int RL   = 2;
  localparam int SL   = 16;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          useModel;
  logic [SW-1:0] manualData;
  logic [WW-1:0] addrD1, addrD2;
  int            checksTotal  = 0;
  int            checksPassed = 0;

  wave_read_arbiter_if #(
    .NUM_OSCILLATORS(NOSC),
    .SAMPLE_WIDTH   (SW),
    .WW_WIDTH       (WW)
  ) bus ();

  wave_read_arbiter #(
    .NUM_OSCILLATORS(NOSC),
    .SAMPLE_WIDTH   (SW),
    .WW_WIDTH       (WW),
    .READ_LATENCY   (RL),
    .STARVE_LIMIT   (SL)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  // 100 MHz clock
  always #5 clk_in = ~clk_in;

  function automatic logic [SW-1:0] memWord(input logic [WW-1:0] a);
    return 16'h8000 | {1'b0, a};
  endfunction

  // BRAM model: data for the address presented two cycles earlier
  always @(posedge clk_in) begin
    addrD1 <= bus.bram_addr_out;
    addrD2 <= addrD1;
  end

  assign bus.bram_data_in = useModel ? memWord(addrD2) : manualData;

  task automatic stepCycle();
    @(negedge clk_in);
  endtask

  task automatic applyStimulus(input logic [NOSC-1:0] oscReq, input logic vizReq,
                               input logic dbgReq);
    bus.osc_req_in = oscReq;
    bus.viz_req_in = vizReq;
    bus.dbg_req_in = dbgReq;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checksTotal++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst_in = 1'b0;
    applyStimulus('0, 1'b0, 1'b0);
    bus.freeze_in = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("reset en", bus.bram_en_out, 0);
    checkOutput("reset addr", bus.bram_addr_out, 0);
    checkOutput("reset osc valid", bus.osc_valid_out, 0);
    checkOutput("reset osc data", bus.osc_data_out, 0);
    checkOutput("reset viz/dbg data", {bus.viz_data_out, bus.dbg_data_out}, 0);
    checkOutput("reset viz/dbg valid", {bus.viz_valid_out, bus.dbg_valid_out}, 0);
    rst_in = 1'b1;
  endtask

  initial begin
    rst_in           = 1'b0;
    useModel         = 1'b0;
    manualData       = '0;
    bus.wave_width_in = '0;
    bus.freeze_in    = 1'b0;
    bus.osc_req_in   = '0;
    bus.osc_index_in = '0;
    bus.viz_req_in   = 1'b0;
    bus.viz_index_in = '0;
    bus.dbg_req_in   = 1'b0;
    bus.dbg_index_in = '0;

    // Single uncontended read with hand-driven BRAM data
    doReset();
    bus.wave_width_in   = 15'd1000;
    bus.osc_index_in[0] = 15'd100;
    applyStimulus(3'b001, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkOutput("single en c1", bus.bram_en_out, 0);
    stepCycle();
    checkOutput("single en c2", bus.bram_en_out, 1);
    checkOutput("single addr c2", bus.bram_addr_out, 100);
    stepCycle();
    checkOutput("single en c3", bus.bram_en_out, 0);
    checkOutput("single addr hold", bus.bram_addr_out, 100);
    stepCycle();
    manualData = 16'h1234;
    checkOutput("single valid c4", bus.osc_valid_out, 0);
    stepCycle();
    manualData = 16'h0000;
    checkOutput("single valid c5", bus.osc_valid_out, 3'b001);
    checkOutput("single data c5", bus.osc_data_out[0], 16'h1234);
    stepCycle();
    checkOutput("single valid c6", bus.osc_valid_out, 0);
    checkOutput("single data hold", bus.osc_data_out[0], 16'h1234);
    useModel = 1'b1;

    // Round-robin: all three oscillators strobe for four cycles
    doReset();
    bus.wave_width_in   = 15'd1000;
    bus.osc_index_in[0] = 15'd10;
    bus.osc_index_in[1] = 15'd11;
    bus.osc_index_in[2] = 15'd12;
    applyStimulus(3'b111, 1'b0, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      stepCycle();
      if (c == 4) applyStimulus(3'b000, 1'b0, 1'b0);
      checkOutput($sformatf("rr en c%0d", c), bus.bram_en_out, (c >= 2 && c <= 7));
      if (c >= 2 && c <= 7) begin
        checkOutput($sformatf("rr addr c%0d", c), bus.bram_addr_out, 10 + ((c - 2) % 3));
      end
      if (c >= 5 && c <= 10) begin
        checkOutput($sformatf("rr valid c%0d", c), bus.osc_valid_out, 1 << ((c - 5) % 3));
        checkOutput($sformatf("rr data c%0d", c), bus.osc_data_out[(c - 5) % 3],
                    16'h800A + ((c - 5) % 3));
      end else begin
        checkOutput($sformatf("rr idle valid c%0d", c), bus.osc_valid_out, 0);
      end
    end

    // Starvation: two busy oscillators, one visualiser request
    doReset();
    bus.wave_width_in   = 15'd1000;
    bus.osc_index_in[0] = 15'd20;
    bus.osc_index_in[1] = 15'd21;
    bus.viz_index_in    = 15'd300;
    applyStimulus(3'b011, 1'b1, 1'b0);
    for (int c = 1; c <= 21; c++) begin
      stepCycle();
      if (c == 1) applyStimulus(3'b011, 1'b0, 1'b0);
      if (c == 21) applyStimulus(3'b000, 1'b0, 1'b0);
      if (c >= 16 && c <= 20) begin
        checkOutput($sformatf("starve en c%0d", c), bus.bram_en_out, 1);
        checkOutput($sformatf("starve addr c%0d", c), bus.bram_addr_out,
                    (c == 16) ? 20 : (c == 17) ? 21 : (c == 18) ? 300 : (c == 19) ? 20 : 21);
      end
      if (c == 20) checkOutput("starve viz valid c20", bus.viz_valid_out, 0);
      if (c == 21) begin
        checkOutput("starve viz valid c21", bus.viz_valid_out, 1);
        checkOutput("starve viz data", bus.viz_data_out, 16'h812C);
      end
    end
    repeat (8) stepCycle();

    // Clamp to wave end, then empty wave
    doReset();
    bus.wave_width_in   = 15'd500;
    bus.osc_index_in[0] = 15'd700;
    applyStimulus(3'b001, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(3'b000, 1'b0, 1'b0);
    stepCycle();
    checkOutput("clamp en", bus.bram_en_out, 1);
    checkOutput("clamp addr", bus.bram_addr_out, 499);
    repeat (3) stepCycle();
    checkOutput("clamp valid", bus.osc_valid_out, 3'b001);
    checkOutput("clamp data", bus.osc_data_out[0], 16'h81F3);
    bus.wave_width_in   = 15'd0;
    bus.osc_index_in[1] = 15'd42;
    applyStimulus(3'b010, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(3'b000, 1'b0, 1'b0);
    stepCycle();
    checkOutput("zero width en", bus.bram_en_out, 1);
    checkOutput("zero width addr", bus.bram_addr_out, 0);
    repeat (4) stepCycle();

    // Overwrite while frozen: index 5 then 9 gives a single read at 9
    bus.wave_width_in   = 15'd1000;
    bus.freeze_in       = 1'b1;
    bus.osc_index_in[2] = 15'd5;
    applyStimulus(3'b100, 1'b0, 1'b0);
    stepCycle();
    bus.osc_index_in[2] = 15'd9;
    stepCycle();
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkOutput("overwrite en c2", bus.bram_en_out, 0);
    stepCycle();
    bus.freeze_in = 1'b0;
    checkOutput("overwrite en c3", bus.bram_en_out, 0);
    stepCycle();
    checkOutput("overwrite en c4", bus.bram_en_out, 1);
    checkOutput("overwrite addr", bus.bram_addr_out, 9);
    stepCycle();
    checkOutput("overwrite single", bus.bram_en_out, 0);
    repeat (4) stepCycle();

    // Strobe on the grant cycle: old index is read, new one stays pending
    bus.osc_index_in[2] = 15'd7;
    applyStimulus(3'b100, 1'b0, 1'b0);
    stepCycle();
    bus.osc_index_in[2] = 15'd8;
    stepCycle();
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkOutput("regrant addr c2", bus.bram_addr_out, 7);
    stepCycle();
    checkOutput("regrant en c3", bus.bram_en_out, 1);
    checkOutput("regrant addr c3", bus.bram_addr_out, 8);
    stepCycle();
    checkOutput("regrant en c4", bus.bram_en_out, 0);

    // Freeze with two reads in flight and three pending
    doReset();
    bus.wave_width_in   = 15'd1000;
    bus.osc_index_in[0] = 15'd30;
    bus.osc_index_in[1] = 15'd31;
    bus.osc_index_in[2] = 15'd32;
    bus.viz_index_in    = 15'd40;
    bus.dbg_index_in    = 15'd41;
    applyStimulus(3'b011, 1'b0, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      stepCycle();
      if (c == 1) applyStimulus(3'b000, 1'b0, 1'b0);
      if (c == 2) applyStimulus(3'b100, 1'b1, 1'b1);
      if (c == 3) begin
        applyStimulus(3'b000, 1'b0, 1'b0);
        bus.freeze_in = 1'b1;
      end
      if (c == 8) bus.freeze_in = 1'b0;
      if (c == 2) checkOutput("freeze addr c2", bus.bram_addr_out, 30);
      if (c == 3) checkOutput("freeze addr c3", bus.bram_addr_out, 31);
      if (c >= 4 && c <= 8) checkOutput($sformatf("freeze en c%0d", c), bus.bram_en_out, 0);
      if (c >= 9 && c <= 11) begin
        checkOutput($sformatf("release en c%0d", c), bus.bram_en_out, 1);
        checkOutput($sformatf("release addr c%0d", c), bus.bram_addr_out,
                    (c == 9) ? 32 : (c == 10) ? 40 : 41);
      end
      if (c == 12) checkOutput("release en c12", bus.bram_en_out, 0);
      if (c == 5) begin
        checkOutput("freeze valid c5", bus.osc_valid_out, 3'b001);
        checkOutput("freeze data c5", bus.osc_data_out[0], 16'h801E);
      end
      if (c == 6) begin
        checkOutput("freeze valid c6", bus.osc_valid_out, 3'b010);
        checkOutput("freeze data c6", bus.osc_data_out[1], 16'h801F);
      end
      if (c == 7) checkOutput("freeze valid c7", bus.osc_valid_out, 0);
      if (c == 12) begin
        checkOutput("release valid osc2", bus.osc_valid_out, 3'b100);
        checkOutput("release data osc2", bus.osc_data_out[2], 16'h8020);
      end
      if (c == 13) begin
        checkOutput("release valid viz", bus.viz_valid_out, 1);
        checkOutput("release data viz", bus.viz_data_out, 16'h8028);
      end
      if (c == 14) begin
        checkOutput("release valid dbg", bus.dbg_valid_out, 1);
        checkOutput("release data dbg", bus.dbg_data_out, 16'h8029);
      end
    end

    // Reset while a read is in flight
    doReset();
    bus.wave_width_in   = 15'd1000;
    bus.osc_index_in[0] = 15'd50;
    applyStimulus(3'b001, 1'b0, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      stepCycle();
      if (c == 1) applyStimulus(3'b000, 1'b0, 1'b0);
      if (c == 2) begin
        checkOutput("midrst addr c2", bus.bram_addr_out, 50);
        rst_in = 1'b0;
      end
      if (c == 3) begin
        rst_in = 1'b1;
        checkOutput("midrst en c3", bus.bram_en_out, 0);
        checkOutput("midrst addr c3", bus.bram_addr_out, 0);
      end
      if (c >= 3 && c <= 7) begin
        checkOutput($sformatf("midrst no valid c%0d", c), bus.osc_valid_out, 0);
      end
      if (c == 7) begin
        bus.osc_index_in[1] = 15'd60;
        applyStimulus(3'b010, 1'b0, 1'b0);
      end
      if (c == 8) applyStimulus(3'b000, 1'b0, 1'b0);
      if (c == 9) begin
        checkOutput("post-rst en", bus.bram_en_out, 1);
        checkOutput("post-rst addr", bus.bram_addr_out, 60);
      end
      if (c == 11) checkOutput("post-rst valid early", bus.osc_valid_out, 0);
      if (c == 12) begin
        checkOutput("post-rst valid", bus.osc_valid_out, 3'b010);
        checkOutput("post-rst data", bus.osc_data_out[1], 16'h803C);
      end
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
